// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package proc_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

    // Default instruction memory depth in words (largest legal frame).
    localparam int DEFAULT_IMEM_DEPTH = 512;

    // Frame header length in bytes (16-bit little-endian word count).
    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes into one little-endian 32-bit word; the first byte of
// a word lands in bits 7:0. The completed word is presented combinationally
// together with word_valid while the 4th byte is on the input.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // The three earlier bytes sit in shift_q; the 4th completes the word.
    assign word = {byte_data, shift_q};

    // Next byte position and shift contents.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = '0;
        end else if (byte_valid) begin
            shift_d    = {byte_data, shift_q[23:8]};
            cnt_d      = cnt_q + 2'd1;
            word_valid = (cnt_q == 2'd3);
        end
    end

    // Byte counter and shift register.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot/reload controller: parses a length-prefixed byte frame, writes the
// assembled words into the core instruction memory while holding the core
// in reset, then releases it. A new frame arriving while running reloads.
module imem_loader
    import proc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int IMEM_DEPTH  = DEFAULT_IMEM_DEPTH,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             ins_mem_en,
    output logic [WIDTH-1:0] ins_mem_addr,
    output logic [WIDTH-1:0] ins_mem_data,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    localparam int          TO_W      = $clog2(TIMEOUT + 1);
    localparam int          HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [15:0] MAX_WORDS = 16'(IMEM_DEPTH);

    loader_state_t    state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      index_q, index_d;
    logic [15:0]      words_q, words_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             en_q, en_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             accept;
    logic             in_frame;
    logic             timed_out;
    logic             word_valid;
    logic [31:0]      word;
    logic [15:0]      hdr_count;

    // Only rx_ready decodes straight from the state register.
    assign rx_ready  = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                       (state_q == ST_DATA) || (state_q == ST_RUN);
    assign accept    = rx_valid & rx_ready;
    assign in_frame  = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign timed_out = in_frame && !accept && (timeout_q == TO_W'(TIMEOUT - 1));
    assign hdr_count = {rx_data, count_q[7:0]};

    // Assembler is held clear outside DATA so every frame starts on byte 0.
    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_q != ST_DATA),
        .byte_valid (accept),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        words_d   = words_q;
        addr_d    = addr_q;
        data_d    = data_q;
        en_d      = 1'b0;
        timeout_d = (in_frame && !accept) ? timeout_q + TO_W'(1) : '0;
        hold_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = {8'h00, rx_data};
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (hdr_count == 16'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        index_d = '0;
                        words_d = '0;
                        state_d = ST_DATA;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    addr_d  = WIDTH'(index_q);
                    data_d  = WIDTH'(word);
                    en_d    = 1'b1;
                    index_d = index_q + 16'd1;
                    words_d = words_q + 16'd1;
                    if (index_q == count_q - 16'd1) begin
                        state_d = ST_HOLD;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HOLD: begin
                // HOLD spans HOLD_CYCLES+1 cycles, the first overlapping the last write.
                if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    count_d = {8'h00, rx_data};
                    words_d = '0;
                    state_d = ST_HDR;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they align with it.
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_HOLD);
        done_d      = (state_d == ST_RUN);
        error_d     = (state_d == ST_ERROR);
    end

    // State, counters and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            index_q     <= '0;
            words_q     <= '0;
            timeout_q   <= '0;
            hold_q      <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            words_q     <= words_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ins_mem_en   = en_q;
    assign ins_mem_addr = addr_q;
    assign ins_mem_data = data_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, reload, zero length,
// oversize, depth boundary, inter-byte timeout and reset mid-word.
module tb_imem_loader;

    localparam int TB_TIMEOUT = 40;

    logic        clock;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        ins_mem_en;
    logic [31:0] ins_mem_addr;
    logic [31:0] ins_mem_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int npulse   = 0;
    int fall_cyc = -1;
    int base;
    logic        cpu_reset_prev = 1'b1;
    logic [31:0] p_addr [0:63];
    logic [31:0] p_data [0:63];
    int          p_cyc  [0:63];

    imem_loader #(
        .WIDTH       (32),
        .IMEM_DEPTH  (512),
        .HOLD_CYCLES (4),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .ins_mem_en   (ins_mem_en),
        .ins_mem_addr (ins_mem_addr),
        .ins_mem_data (ins_mem_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Log every write strobe and the cycle cpu_reset falls, sampled mid-cycle.
    always @(negedge clock) begin
        if (ins_mem_en) begin
            if (npulse < 64) begin
                p_addr[npulse] = ins_mem_addr;
                p_data[npulse] = ins_mem_data;
                p_cyc[npulse]  = cyc;
            end
            npulse = npulse + 1;
        end
        if (cpu_reset_prev && !cpu_reset) fall_cyc = cyc;
        cpu_reset_prev = cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Present one byte and return #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        @(negedge clock);
        while (!rx_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!rx_ready) check("send_byte_ready", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();

        // Reset values
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_en", 32'(ins_mem_en), 32'd0);
        check("rst_addr", ins_mem_addr, 32'd0);
        check("rst_data", ins_mem_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Normal load: two words, back-to-back bytes
        base = npulse;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hB3); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("hold_rx_ready", 32'(rx_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        wait_cycles(10);
        check("load_npulse", 32'(npulse - base), 32'd2);
        check("load_addr0", p_addr[base], 32'd0);
        check("load_data0", p_data[base], 32'h0000_0013);
        check("load_addr1", p_addr[base+1], 32'd1);
        check("load_data1", p_data[base+1], 32'h0000_00B3);
        check("load_spacing", 32'(p_cyc[base+1] - p_cyc[base]), 32'd4);
        check("load_release", 32'(fall_cyc - p_cyc[base+1]), 32'd5);
        check("load_done", 32'(done), 32'd1);
        check("load_words", 32'(words_loaded), 32'd2);
        check("load_cpu_reset", 32'(cpu_reset), 32'd0);
        check("load_busy", 32'(busy), 32'd0);
        check("run_rx_ready", 32'(rx_ready), 32'd1);

        // Reload from RUN
        base = npulse;
        send_byte(8'h01);
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_words_clr", 32'(words_loaded), 32'd0);
        send_byte(8'h00);
        send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_cycles(10);
        check("reload_npulse", 32'(npulse - base), 32'd1);
        check("reload_addr", p_addr[base], 32'd0);
        check("reload_data", p_data[base], 32'h0000_006F);
        check("reload_words", 32'(words_loaded), 32'd1);
        check("reload_run", 32'(done), 32'd1);

        // Zero-length frame
        do_reset();
        base = npulse;
        send_byte(8'h00); send_byte(8'h00);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_rx_ready", 32'(rx_ready), 32'd0);
        wait_cycles(10);
        check("zero_npulse", 32'(npulse - base), 32'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd0);

        // Oversize frame (N = 513), byte left waiting on the link
        do_reset();
        send_byte(8'h01); send_byte(8'h02);
        check("over_error", 32'(error), 32'd1);
        check("over_cpu_reset", 32'(cpu_reset), 32'd1);
        check("over_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        wait_cycles(3);
        check("over_stuck_error", 32'(error), 32'd1);
        check("over_stuck_ready", 32'(rx_ready), 32'd0);
        check("over_busy", 32'(busy), 32'd0);
        rx_valid = 1'b0;

        // Depth boundary (N = 512) is legal
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        check("max_error", 32'(error), 32'd0);
        check("max_busy", 32'(busy), 32'd1);

        // Inter-byte timeout inside a word
        do_reset();
        base = npulse;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        wait_cycles(TB_TIMEOUT - 1);
        check("to_not_yet", 32'(error), 32'd0);
        wait_cycles(1);
        check("to_error", 32'(error), 32'd1);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);
        check("to_npulse", 32'(npulse - base), 32'd0);

        // Reset after two data bytes, then a clean frame
        do_reset();
        base = npulse;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_words", 32'(words_loaded), 32'd0);
        check("mid_data", ins_mem_data, 32'd0);
        wait_cycles(3);
        check("mid_npulse", 32'(npulse - base), 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        wait_cycles(10);
        check("after_npulse", 32'(npulse - base), 32'd1);
        check("after_addr", p_addr[base], 32'd0);
        check("after_data", p_data[base], 32'h1122_3344);
        check("after_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
